// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants and types for the regfile writeback arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DW     = 64;
    localparam int AW     = 5;
    localparam int NREG   = 32;
    localparam int ZR_IDX = 31;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [DW-1:0] reg_data_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t addr;
        reg_data_t data;
    } wb_req_t;

    // Zero-register index at address width, for direct comparison with addresses.
    localparam reg_addr_t ZR_ADDR = AW'(ZR_IDX);

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter_if
// Description : Writeback request handshakes and regfile write port bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if;
    import regfile_pkg::*;

    logic      req0_valid;
    reg_addr_t req0_addr;
    reg_data_t req0_data;
    logic      req0_ready;

    logic      req1_valid;
    reg_addr_t req1_addr;
    reg_data_t req1_data;
    logic      req1_ready;

    logic      we3;
    reg_addr_t wa3;
    reg_data_t wd3;

    // Requesters side: drive requests, observe handshake and write port.
    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  we3, wa3, wd3
    );

    // Arbiter side: accept requests, drive handshake and regfile write port.
    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output we3, wa3, wd3
    );

endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin arbiter with one-hot grant. The last
//               pointer resets to 1 so requester 0 wins the first conflict.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  wire logic       clk,
    input  wire logic       reset_n,
    input  wire logic [1:0] req,
    output logic      [1:0] gnt
);

    logic       last_q;
    logic       last_d;
    logic [1:0] gnt_raw;

    // Grant selection: single requester wins outright, conflicts go to the
    // requester not granted last; no grant is issued while reset is held.
    always_comb begin
        gnt_raw = 2'b00;
        last_d  = last_q;
        case (req)
            2'b01:   gnt_raw = 2'b01;
            2'b10:   gnt_raw = 2'b10;
            2'b11:   gnt_raw = last_q ? 2'b01 : 2'b10;
            default: gnt_raw = 2'b00;
        endcase
        if (gnt_raw[1]) begin
            last_d = 1'b1;
        end else if (gnt_raw[0]) begin
            last_d = 1'b0;
        end
        gnt = reset_n ? gnt_raw : 2'b00;
    end

    // Remember which requester was granted most recently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the regfile write port between the ALU (req0) and load
//               (req1) writeback paths and tracks in-flight destination
//               registers in a busy scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      reset_n,
    input  wire logic      iss_valid,
    input  wire reg_addr_t iss_rd,
    input  wire reg_addr_t ra1,
    input  wire reg_addr_t ra2,
    output logic           busy1,
    output logic           busy2,
    output logic           idle,
    regfile_wb_arbiter_if.slave wb
);

    wb_req_t         req0_s;
    wb_req_t         req1_s;
    wb_req_t         sel_s;
    logic [1:0]      req_vec;
    logic [1:0]      gnt;
    logic            accept;

    logic            we3_q, we3_d;
    reg_addr_t       wa3_q, wa3_d;
    reg_data_t       wd3_q, wd3_d;
    logic [NREG-1:0] busy_q, busy_d;

    // Pack the two requesters for uniform muxing.
    always_comb begin
        req0_s  = '{valid: wb.req0_valid, addr: wb.req0_addr, data: wb.req0_data};
        req1_s  = '{valid: wb.req1_valid, addr: wb.req1_addr, data: wb.req1_data};
        req_vec = {wb.req1_valid, wb.req0_valid};
    end

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req_vec),
        .gnt     (gnt)
    );

    assign wb.req0_ready = gnt[0];
    assign wb.req1_ready = gnt[1];

    // Select the granted request and form the next write-port values; a write
    // to the zero register completes its handshake but is dropped here.
    always_comb begin
        sel_s  = gnt[1] ? req1_s : req0_s;
        accept = (|gnt) && sel_s.valid;
        we3_d  = 1'b0;
        wa3_d  = wa3_q;
        wd3_d  = wd3_q;
        if (accept && (sel_s.addr != ZR_ADDR)) begin
            we3_d = 1'b1;
            wa3_d = sel_s.addr;
            wd3_d = sel_s.data;
        end
    end

    // Scoreboard update: clear on the regfile commit edge, then apply the
    // issue set so a newer in-flight writer keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (we3_q) begin
            busy_d[wa3_q] = 1'b0;
        end
        if (iss_valid && (iss_rd != ZR_ADDR)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[ZR_IDX] = 1'b0;
    end

    // Registered write port and scoreboard state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we3_q  <= 1'b0;
            wa3_q  <= '0;
            wd3_q  <= '0;
            busy_q <= '0;
        end else begin
            we3_q  <= we3_d;
            wa3_q  <= wa3_d;
            wd3_q  <= wd3_d;
            busy_q <= busy_d;
        end
    end

    assign wb.we3 = we3_q;
    assign wb.wa3 = wa3_q;
    assign wb.wd3 = wd3_q;

    // Scoreboard queries and idle status straight from current state.
    always_comb begin
        busy1 = busy_q[ra1];
        busy2 = busy_q[ra2];
        idle  = (busy_q == '0) && !we3_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed self-checking bench for regfile_wb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    logic      clk;
    logic      reset_n;
    logic      iss_valid;
    reg_addr_t iss_rd;
    reg_addr_t ra1;
    reg_addr_t ra2;
    logic      busy1;
    logic      busy2;
    logic      idle;

    int n_vec;
    int n_err;

    regfile_wb_arbiter_if u_if ();

    regfile_wb_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .ra1       (ra1),
        .ra2       (ra2),
        .busy1     (busy1),
        .busy2     (busy2),
        .idle      (idle),
        .wb        (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_n   = 1'b0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        ra1       = '0;
        ra2       = '0;
        u_if.req0_valid = 1'b0;
        u_if.req0_addr  = '0;
        u_if.req0_data  = '0;
        u_if.req1_valid = 1'b0;
        u_if.req1_addr  = '0;
        u_if.req1_data  = '0;

        // Reset and release, no traffic.
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("rst_we3",   u_if.we3, 64'd0);
        check("rst_wa3",   u_if.wa3, 64'd0);
        check("rst_wd3",   u_if.wd3, 64'd0);
        check("rst_busy1", busy1, 64'd0);
        check("rst_busy2", busy2, 64'd0);
        check("rst_idle",  idle, 64'd1);
        check("rst_rdy0",  u_if.req0_ready, 64'd0);

        // Issue r5, then ALU writeback to r5 two cycles later.
        ra1 = 5'd5;
        iss_valid = 1'b1;
        iss_rd    = 5'd5;
        tick();
        iss_valid = 1'b0;
        check("iss5_busy1", busy1, 64'd1);
        check("iss5_idle",  idle, 64'd0);
        tick();
        u_if.req0_valid = 1'b1;
        u_if.req0_addr  = 5'd5;
        u_if.req0_data  = 64'hDEAD;
        #1;
        check("wb5_rdy0", u_if.req0_ready, 64'd1);
        check("wb5_rdy1", u_if.req1_ready, 64'd0);
        tick();
        u_if.req0_valid = 1'b0;
        check("wb5_we3",   u_if.we3, 64'd1);
        check("wb5_wa3",   u_if.wa3, 64'd5);
        check("wb5_wd3",   u_if.wd3, 64'hDEAD);
        check("wb5_busy1", busy1, 64'd1);
        tick();
        check("wb5_we3_off", u_if.we3, 64'd0);
        check("wb5_cleared", busy1, 64'd0);
        check("wb5_idle",    idle, 64'd1);

        // Load writeback to zero register: handshake completes, write dropped.
        u_if.req1_valid = 1'b1;
        u_if.req1_addr  = 5'd31;
        u_if.req1_data  = 64'd7;
        #1;
        check("zr_rdy1", u_if.req1_ready, 64'd1);
        check("zr_rdy0", u_if.req0_ready, 64'd0);
        tick();
        u_if.req1_valid = 1'b0;
        check("zr_we3",      u_if.we3, 64'd0);
        check("zr_wa3_hold", u_if.wa3, 64'd5);
        check("zr_wd3_hold", u_if.wd3, 64'hDEAD);
        ra2 = 5'd31;
        iss_valid = 1'b1;
        iss_rd    = 5'd31;
        tick();
        iss_valid = 1'b0;
        check("zr_busy2", busy2, 64'd0);
        check("zr_idle",  idle, 64'd1);

        // Both requesters valid for four cycles: grants alternate 0,1,0,1.
        u_if.req0_valid = 1'b1;
        u_if.req0_addr  = 5'd1;
        u_if.req0_data  = 64'h11;
        u_if.req1_valid = 1'b1;
        u_if.req1_addr  = 5'd2;
        u_if.req1_data  = 64'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("alt_rdy0", u_if.req0_ready, (i % 2 == 0) ? 64'd1 : 64'd0);
            check("alt_rdy1", u_if.req1_ready, (i % 2 == 0) ? 64'd0 : 64'd1);
            tick();
            check("alt_we3", u_if.we3, 64'd1);
            check("alt_wa3", u_if.wa3, (i % 2 == 0) ? 64'd1 : 64'd2);
            check("alt_wd3", u_if.wd3, (i % 2 == 0) ? 64'h11 : 64'h22);
        end
        u_if.req0_valid = 1'b0;
        u_if.req1_valid = 1'b0;
        tick();

        // req1 stalls while req0 is granted, then is accepted with its data intact.
        u_if.req0_valid = 1'b1;
        u_if.req0_addr  = 5'd4;
        u_if.req0_data  = 64'h44;
        u_if.req1_valid = 1'b1;
        u_if.req1_addr  = 5'd6;
        u_if.req1_data  = 64'hCAFE_F00D_1234_5678;
        #1;
        check("stall_rdy0", u_if.req0_ready, 64'd1);
        check("stall_rdy1", u_if.req1_ready, 64'd0);
        tick();
        u_if.req0_valid = 1'b0;
        check("stall_wa3_0", u_if.wa3, 64'd4);
        check("stall_wd3_0", u_if.wd3, 64'h44);
        #1;
        check("stall_rdy1_go", u_if.req1_ready, 64'd1);
        tick();
        u_if.req1_valid = 1'b0;
        check("stall_we3",   u_if.we3, 64'd1);
        check("stall_wa3_1", u_if.wa3, 64'd6);
        check("stall_wd3_1", u_if.wd3, 64'hCAFE_F00D_1234_5678);

        // Set wins over clear on the same register.
        ra1 = 5'd9;
        iss_valid = 1'b1;
        iss_rd    = 5'd9;
        tick();
        iss_valid = 1'b0;
        u_if.req0_valid = 1'b1;
        u_if.req0_addr  = 5'd9;
        u_if.req0_data  = 64'h99;
        tick();
        u_if.req0_valid = 1'b0;
        check("sw_we3", u_if.we3, 64'd1);
        check("sw_wa3", u_if.wa3, 64'd9);
        iss_valid = 1'b1;
        iss_rd    = 5'd9;
        tick();
        iss_valid = 1'b0;
        check("sw_busy1", busy1, 64'd1);
        tick();
        check("sw_busy1_hold", busy1, 64'd1);

        // Asynchronous reset during an in-flight write.
        ra2 = 5'd8;
        iss_valid = 1'b1;
        iss_rd    = 5'd8;
        u_if.req0_valid = 1'b1;
        u_if.req0_addr  = 5'd7;
        u_if.req0_data  = 64'h77;
        tick();
        iss_valid = 1'b0;
        check("mid_we3",   u_if.we3, 64'd1);
        check("mid_busy2", busy2, 64'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_we3",   u_if.we3, 64'd0);
        check("mid_rst_wa3",   u_if.wa3, 64'd0);
        check("mid_rst_wd3",   u_if.wd3, 64'd0);
        check("mid_rst_busy1", busy1, 64'd0);
        check("mid_rst_busy2", busy2, 64'd0);
        check("mid_rst_rdy0",  u_if.req0_ready, 64'd0);
        u_if.req0_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check("final_idle", idle, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (we3/wa3/wd3) between two writeback requesters: req0 is the ALU path and req1 is the multi-cycle load path.
- Keeps a 32-entry busy scoreboard so that issue logic can stall on registers with an in-flight write.
- Sits between the execute/memory stages and regfile; its outputs drive the regfile write port directly.

Parameters:
- DW, 64, data width of the write port.
- AW, 5, register address width.
- NREG, 32, number of architectural registers.
- ZR_IDX, 31, index of the zero register; it is never written and never marked busy.

Ports:
- clk  in  1  clock; all state updates on the posedge.
- reset_n  in  1  asynchronous, active-low reset.
- iss_valid  in  1  issue of an instruction that will write iss_rd.
- iss_rd  in  AW  destination register of the issued instruction.
- req0_valid  in  1  ALU writeback request.
- req0_addr  in  AW  ALU writeback register.
- req0_data  in  DW  ALU writeback data.
- req0_ready  out  1  ALU request accepted this cycle.
- req1_valid  in  1  load writeback request.
- req1_addr  in  AW  load writeback register.
- req1_data  in  DW  load writeback data.
- req1_ready  out  1  load request accepted this cycle.
- we3  out  1  regfile write enable (registered).
- wa3  out  AW  regfile write address (registered).
- wd3  out  DW  regfile write data (registered).
- ra1  in  AW  scoreboard query address 1.
- ra2  in  AW  scoreboard query address 2.
- busy1  out  1  busy[ra1], combinational.
- busy2  out  1  busy[ra2], combinational.
- idle  out  1  no busy bits set and we3==0.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - we3=0, wa3=0, wd3=0.
  - All busy bits cleared; round-robin pointer last=1, so req0 wins first.
  - req0_ready=req1_ready=0 while reset is held. An in-flight write is discarded.
- Arbitration (combinational, per cycle):
  - Only one valid request: that requester is granted.
  - Both valid: grant the requester not granted last.
  - On any grant, last <= granted index.
  - reqN_ready=1 only for the granted requester.
  - A request is accepted when valid&&ready. Requesters hold addr/data stable until accepted.
- Write port, 1-cycle latency:
  - On acceptance of addr!=ZR_IDX: next edge sets we3=1, wa3=addr, wd3=data.
  - On acceptance of addr==ZR_IDX: the handshake completes but we3=0 next cycle (write dropped).
  - No acceptance: we3=0; wa3/wd3 hold their previous values.
  - Maximum throughput is one write per cycle; back-to-back grants are allowed.
- Scoreboard, 32 bits:
  - Set: iss_valid && iss_rd!=ZR_IDX sets busy[iss_rd] at the next edge.
  - Clear: we3==1 clears busy[wa3] at that edge. This is the same edge on which regfile commits wd3, so busy always reflects regfile contents.
  - Simultaneous set and clear of the same register: set wins, because a newer writer is in flight.
  - busy[ZR_IDX] is constant 0.
  - Issuing a register that is already busy keeps it busy; there is no counting, and the issue stage guarantees in-order writeback per register.
- Queries:
  - busy1/busy2 are purely combinational from current state.
  - There is no bypass of same-cycle iss_valid or we3.
- idle: combinational, = (busy==0) && !we3.

Decomposition:
- Package regfile_pkg holds:
  - constants DW, AW, NREG, ZR_IDX;
  - typedef reg_addr_t (logic [AW-1:0]);
  - typedef reg_data_t (logic [DW-1:0]);
  - typedef wb_req_t (struct of valid, addr, data).
- Sub-module rr_arbiter2: 2-way round-robin arbiter.
  - Inputs: req[1:0], clk, reset_n.
  - Outputs: one-hot gnt[1:0].
  - Owns the last pointer.
- Scoreboard and output registers stay in the top level.

Test Plan:
- Reset release, no traffic -> we3=0, busy1=busy2=0, idle=1. Assert reset_n=0 mid-write (we3=1) -> we3=0 immediately, all busy cleared.
- iss_valid, iss_rd=5 at cycle 0; req0 {addr=5, data=64'hDEAD} at cycle 2 -> req0_ready=1 at cycle 2; we3=1, wa3=5, wd3=DEAD at cycle 3; busy[5]=1 through cycle 3 and 0 at cycle 4; idle=1 at cycle 4.
- req0 and req1 both valid for 4 cycles, addrs 1 and 2 -> grants alternate 0,1,0,1; wa3 sequence is 1,2,1,2 on consecutive cycles.
- req1 {addr=31, data=7} -> req1_ready=1, next cycle we3=0. Separately, iss_rd=31 -> busy2 stays 0 with ra2=31.
- Cycle n: we3=1, wa3=9 and iss_valid, iss_rd=9 -> busy[9]=1 after the edge (set wins).
- req1 held valid while req0 is granted once -> req1 stays stalled with stable data, is accepted the next cycle, and data matches wd3 exactly.
